// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: ID/EX hazard sources in, stall/flush controls out.
// Optional HAZARD_PERF_EN adds the stall_count/flush_count performance counters.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_wreg;
    logic        ex_branch_taken;
    logic        id_jump;
    logic        ex_md_start;

    logic        pc_nwrite;
    logic        if2id_nwrite;
    logic        if2id_flush;
    logic        id2ex_flush;
    logic        md_busy;
    logic [1:0]  state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_wreg,
               ex_branch_taken, id_jump, ex_md_start,
        input  pc_nwrite, if2id_nwrite, if2id_flush, id2ex_flush, md_busy, state
`ifdef HAZARD_PERF_EN
        , input stall_count, flush_count
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_wreg,
               ex_branch_taken, id_jump, ex_md_start,
        output pc_nwrite, if2id_nwrite, if2id_flush, id2ex_flush, md_busy, state
`ifdef HAZARD_PERF_EN
        , output stall_count, flush_count
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle mul/div freeze, branch/jump flushes.
// Define HAZARD_PERF_EN to add stall/flush performance counters.
module hazard_ctrl #(
    parameter int MD_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        MDWAIT  = 2'd2
    } state_t;

    state_t     state_q, state_n;
    logic [3:0] count_q, count_n;
    logic       load_use;

    // Register 0 is hardwired, so it can never be a real producer.
    assign load_use = hz.ex_mem_read && (hz.ex_wreg != 5'd0) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.ex_wreg)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.ex_wreg)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            count_q <= 4'd0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n         = state_q;
        count_n         = count_q;
        hz.pc_nwrite    = 1'b0;
        hz.if2id_nwrite = 1'b0;
        hz.if2id_flush  = 1'b0;
        hz.id2ex_flush  = 1'b0;
        hz.md_busy      = 1'b0;
        hz.state        = 2'd0;

        if (reset) begin
            hz.state = state_q;
            if (hz.ex_branch_taken) begin
                // A taken branch squashes everything, including an in-flight mul/div wait.
                hz.if2id_flush = 1'b1;
                hz.id2ex_flush = 1'b1;
                state_n        = RUN;
                count_n        = 4'd0;
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (hz.ex_md_start) begin
                            hz.pc_nwrite    = 1'b1;
                            hz.if2id_nwrite = 1'b1;
                            hz.id2ex_flush  = 1'b1;
                            count_n         = 4'(MD_CYCLES - 1);
                            state_n         = MDWAIT;
                        end else if (load_use) begin
                            hz.pc_nwrite    = 1'b1;
                            hz.if2id_nwrite = 1'b1;
                            hz.id2ex_flush  = 1'b1;
                            state_n         = LOADUSE;
                        end else if (hz.id_jump) begin
                            hz.if2id_flush  = 1'b1;
                        end
                    end
                    LOADUSE: begin
                        state_n = RUN;
                    end
                    MDWAIT: begin
                        hz.pc_nwrite    = 1'b1;
                        hz.if2id_nwrite = 1'b1;
                        hz.id2ex_flush  = 1'b1;
                        hz.md_busy      = 1'b1;
                        count_n         = count_q - 4'd1;
                        if (count_q == 4'd1) state_n = RUN;
                    end
                    default: begin
                        state_n = RUN;
                        count_n = 4'd0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (hz.pc_nwrite)   stall_q <= stall_q + 32'd1;
            if (hz.if2id_flush) flush_q <= flush_q + 32'd1;
        end
    end

    assign hz.stall_count = stall_q;
    assign hz.flush_count = flush_q;
`endif

endmodule
